lsu_bus_master: RTL and testbench

//  Load/store initiator between the CPU execute stage and a handshaked data-memory bus.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 75 +++++++
 rtl/lsu_bus_master.sv | 142 ++++++++++++++
 tb/tb_lsu_bus_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: RV32 funct3 codes,
// FSM state type, datapath widths and the funct3 legality check.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned F3_W_ = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [F3_W_-1:0] F3_B  = 3'b000;
  localparam logic [F3_W_-1:0] F3_H  = 3'b001;
  localparam logic [F3_W_-1:0] F3_W  = 3'b010;
  localparam logic [F3_W_-1:0] F3_BU = 3'b100;
  localparam logic [F3_W_-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  // Stores accept B/H/W only; loads additionally accept BU/HU.
  function automatic logic is_legal(input logic we, input logic [F3_W_-1:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store bus master.
// Ports:
//   funct3    : access size/signedness (RV32 encoding)
//   addr      : byte offset within the word
//   wdata     : right-aligned store data
//   rdata     : full bus read word
//   be        : byte enables for the access
//   wdata_rep : store data replicated across all lanes
//   rdata_ext : selected lane, sign/zero extended
//   misalign  : access not naturally aligned (illegal funct3 is not flagged here)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [F3_W_-1:0] funct3,
  input  logic [1:0]       addr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [BE_W-1:0]  be,
  output logic [XLEN-1:0]  wdata_rep,
  output logic [XLEN-1:0]  rdata_ext,
  output logic             misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection for load extraction
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent enables, replication, extension and alignment
  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = BE_W'(4'b0001 << addr);
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{byte_lane[7]}}, byte_lane}
                                     : {24'b0, byte_lane};
      end
      F3_H, F3_HU: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{half_lane[15]}}, half_lane}
                                     : {16'b0, half_lane};
        misalign  = addr[0];
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = (addr != 2'b00);
      end
      default: begin
        be        = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: accepts one CPU request, checks it, runs a req/ack
// bus transaction with timeout and returns extended load data.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   lsu_req/we/funct3/addr/wdata : CPU request (sampled only when idle)
//   lsu_busy/done/rdata/misalign/timeout : CPU status and result
//   bus_req/we/addr/be/wdata : bus request, held until ack or timeout
//   bus_ack/bus_rdata  : bus response
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lsu_req,
  input  logic             lsu_we,
  input  logic [2:0]       lsu_funct3,
  input  logic [31:0]      lsu_addr,
  input  logic [31:0]      lsu_wdata,
  output logic             lsu_busy,
  output logic             lsu_done,
  output logic [31:0]      lsu_rdata,
  output logic             lsu_misalign,
  output logic             lsu_timeout,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_be,
  output logic [31:0]      bus_wdata,
  input  logic             bus_ack,
  input  logic [31:0]      bus_rdata
);

  lsu_state_t        state;
  logic              we_q;
  logic [F3_W_-1:0]  f3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt;

  logic [F3_W_-1:0]  la_f3;
  logic [1:0]        la_off;
  logic [BE_W-1:0]   la_be;
  logic [XLEN-1:0]   la_wdata_rep;
  logic [XLEN-1:0]   la_rdata_ext;
  logic              la_misalign;

  // Idle: evaluate the incoming request; otherwise: the registered one
  assign la_f3  = (state == IDLE) ? lsu_funct3     : f3_q;
  assign la_off = (state == IDLE) ? lsu_addr[1:0]  : off_q;

  lsu_lane_align u_lane (
    .funct3    (la_f3),
    .addr      (la_off),
    .wdata     (lsu_wdata),
    .rdata     (bus_rdata),
    .be        (la_be),
    .wdata_rep (la_wdata_rep),
    .rdata_ext (la_rdata_ext),
    .misalign  (la_misalign)
  );

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      cnt          <= '0;
      lsu_busy     <= 1'b0;
      lsu_done     <= 1'b0;
      lsu_rdata    <= '0;
      lsu_misalign <= 1'b0;
      lsu_timeout  <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req) begin
            we_q     <= lsu_we;
            f3_q     <= lsu_funct3;
            off_q    <= lsu_addr[1:0];
            lsu_busy <= 1'b1;
            if (!is_legal(lsu_we, lsu_funct3) || la_misalign) begin
              // Rejected requests finish without touching the bus
              state        <= DONE;
              lsu_done     <= 1'b1;
              lsu_misalign <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= lsu_we;
              bus_addr  <= {lsu_addr[31:2], 2'b00};
              bus_be    <= la_be;
              bus_wdata <= lsu_we ? la_wdata_rep : '0;
            end
          end
        end
        REQ: begin
          if (bus_ack || ((TIMEOUT_CYCLES != 0) &&
                          (cnt == CNT_W'(TIMEOUT_CYCLES - 1)))) begin
            state     <= DONE;
            lsu_done  <= 1'b1;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            if (bus_ack) begin
              if (!we_q) lsu_rdata <= la_rdata_ext;
            end else begin
              lsu_timeout <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state        <= IDLE;
          lsu_busy     <= 1'b0;
          lsu_done     <= 1'b0;
          lsu_misalign <= 1'b0;
          lsu_timeout  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          lsu_busy <= 1'b0;
          lsu_done <= 1'b0;
          bus_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: directed scenarios plus random
// requests checked against a size/offset arithmetic reference model.
module tb_lsu_bus_master;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_req      (lsu_req),
    .lsu_we       (lsu_we),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_busy     (lsu_busy),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .lsu_timeout  (lsu_timeout),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    logic        timeout;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  bus_exp_t    cur_bus;
  done_exp_t   cur_done;
  logic        prev_req;
  logic [31:0] exp_rdata;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size/offset arithmetic, no lane muxing
  function automatic void ref_op(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, output bit bus,
                                 output logic [3:0] be, output logic [31:0] wrep,
                                 output logic [31:0] lext);
    int size;
    bit sgn;
    bit legal;
    int off;
    logic [31:0] v;
    size = 0; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; legal = !we; end
      3'd5: begin size = 2; sgn = 0; legal = !we; end
      default: legal = 0;
    endcase
    off  = int'(addr % 4);
    bus  = legal && (size != 0) && (off % size == 0);
    be   = bus ? 4'(((1 << size) - 1) << off) : 4'h0;
    wrep = 32'h0;
    if (we) begin
      if (size == 1)      wrep = (wdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) wrep = (wdata & 32'hFFFF) * 32'h0001_0001;
      else                wrep = wdata;
    end
    v = rdata >> (8 * off);
    if (size == 1)      v = v & 32'hFF;
    else if (size == 2) v = v & 32'hFFFF;
    if (sgn && size < 4 && v >= 32'(1 << (8 * size - 1)))
      v = v - 32'(1 << (8 * size));
    lext = v;
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (lsu_done) begin
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0 @%0t", $time);
      end else begin
        cur_done = done_q.pop_front();
        chk("lsu_rdata", lsu_rdata, cur_done.rdata);
        chk("lsu_misalign", 32'(lsu_misalign), 32'(cur_done.misalign));
        chk("lsu_timeout", 32'(lsu_timeout), 32'(cur_done.timeout));
      end
    end
  end

  // Bus monitor: each new bus_req pops one expectation; fields checked every REQ cycle
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_bus_req actual=1 required=0 @%0t", $time);
      end else begin
        cur_bus = bus_q.pop_front();
      end
    end
    if (bus_req) begin
      chk("bus_addr", bus_addr, cur_bus.addr);
      chk("bus_be", 32'(bus_be), 32'(cur_bus.be));
      chk("bus_wdata", bus_wdata, cur_bus.wdata);
      chk("bus_we", 32'(bus_we), 32'(cur_bus.we));
    end
    prev_req = bus_req;
  end

  // One request; w<0 means the responder never acks
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int w, input bit pulse);
    bit          bus;
    bit          to;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] lext;
    int          explat;
    int          lat;
    bus_exp_t    be_e;
    done_exp_t   de_e;
    ref_op(we, f3, addr, wdata, rdata, bus, be, wrep, lext);
    to = bus && (w < 0);
    if (bus) begin
      be_e.addr = addr & 32'hFFFF_FFFC; be_e.be = be; be_e.wdata = wrep; be_e.we = we;
      bus_q.push_back(be_e);
    end
    if (bus && !to && !we) exp_rdata = lext;
    de_e.rdata = exp_rdata; de_e.misalign = !bus; de_e.timeout = to;
    done_q.push_back(de_e);
    explat = !bus ? 0 : (to ? int'(TO) : w + 1);

    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    bus_rdata = rdata;
    @(posedge clk); #1;
    lsu_req = 1'b0;
    lat = 0;
    while (!lsu_done && lat < 64) begin
      bus_ack = bus && !to && (lat == w);
      lsu_req = pulse && (lat == 0);
      @(posedge clk); #1;
      lat++;
    end
    bus_ack = 1'b0;
    lsu_req = 1'b0;
    chk("done_latency", 32'(lat), 32'(explat));
    // After a timeout, a late ack during DONE must have no effect
    bus_ack = to;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("done_one_cycle", 32'(lsu_done), 32'h0);
    chk("busy_after_done", 32'(lsu_busy), 32'h0);
    if (to) begin
      @(posedge clk); #1;
      chk("late_ack_bus_req", 32'(bus_req), 32'h0);
      chk("late_ack_busy", 32'(lsu_busy), 32'h0);
    end
  endtask

  initial begin
    int w;
    total = 0; bad = 0; exp_rdata = 32'h0; prev_req = 1'b0;
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'h0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(lsu_busy), 32'h0);
    chk("rst_done", 32'(lsu_done), 32'h0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_flags", 32'({lsu_misalign, lsu_timeout}), 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_fields", 32'({bus_we, bus_be}) | bus_addr | bus_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0, 1'b0);
    do_op(1'b0, 3'd0, 32'h0000_0021, 32'h0, 32'h1234_80FF, 3, 1'b0);
    do_op(1'b0, 3'd4, 32'h0000_0021, 32'h0, 32'h1234_80FF, 3, 1'b0);
    do_op(1'b0, 3'd1, 32'h0000_0022, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h5555_5555, 0, 1'b0);
    do_op(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, -1, 1'b0);
    do_op(1'b1, 3'd4, 32'h0000_0008, 32'h1111_2222, 32'h0, 0, 1'b0);
    do_op(1'b0, 3'd5, 32'h0000_0032, 32'h0, 32'hF00D_1234, 2, 1'b1);

    // Reset during the second REQ cycle
    begin
      bus_exp_t e;
      e.addr = 32'h0000_0080; e.be = 4'hF; e.wdata = 32'h0BAD_CAFE; e.we = 1'b1;
      bus_q.push_back(e);
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'd2;
      lsu_addr = 32'h0000_0080; lsu_wdata = 32'h0BAD_CAFE;
      @(posedge clk); #1;
      lsu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_bus_req", 32'(bus_req), 32'h0);
      chk("rst_mid_busy", 32'(lsu_busy), 32'h0);
      chk("rst_mid_done", 32'(lsu_done), 32'h0);
      chk("rst_mid_rdata", lsu_rdata, 32'h0);
      exp_rdata = 32'h0;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
    do_op(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 4));
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, w, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_done", 32'(done_q.size()), 32'h0);
    chk("pending_bus", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
